// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the operand fetch / bypass logic.
package cpu_pipe_pkg;

  localparam int WORD_W = 32;
  localparam int RADDR_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [RADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand against in-flight EX/MEM/WB producers and flags
// when the value cannot be produced yet.
module operand_bypass
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              use_op,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fw_valid,
  input  logic [REG_AW-1:0] ex_fw_dst,
  input  logic              ex_fw_regwr,
  input  logic              ex_fw_isload,
  input  logic [DATA_W-1:0] ex_fw_result,
  input  logic              mem_fw_valid,
  input  logic [REG_AW-1:0] mem_fw_dst,
  input  logic              mem_fw_regwr,
  input  logic              mem_fw_data_ok,
  input  logic [DATA_W-1:0] mem_fw_result,
  input  logic              wb_rfwr,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output fwd_sel_e          sel,
  output logic              stall_req
);

  logic nz, ex_hit, mem_hit, wb_hit;

  assign nz      = (addr != '0);
  assign ex_hit  = nz & ex_fw_valid & ex_fw_regwr & (ex_fw_dst == addr);
  assign mem_hit = nz & mem_fw_valid & mem_fw_regwr & (mem_fw_dst == addr);
  assign wb_hit  = nz & wb_rfwr & (wb_dst == addr);

  always_comb begin
    sel = FWD_RF;
    if (!nz)                          sel = FWD_ZERO;
    else if (ex_hit && !ex_fw_isload) sel = FWD_EX;
    else if (mem_hit && mem_fw_data_ok) sel = FWD_MEM;
    else if (wb_hit)                  sel = FWD_WB;
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_EX:   data = ex_fw_result;
      FWD_MEM:  data = mem_fw_result;
      FWD_WB:   data = wb_result;
      default:  data = rf_data;
    endcase
  end

  // The youngest matching producer decides; an EX non-load hides an older MEM.
  assign stall_req = use_op & (ex_hit ? ex_fw_isload : (mem_hit & ~mem_fw_data_ok));

endmodule

// File: rtl/id_operand_stage.sv
// ID operand-fetch tail: bypass for rs/rt, hazard stall, ID/EX register and
// stall-cycle counter.
module id_operand_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int CTRL_W     = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_allowin,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [DATA_W-1:0]     id_busA,
  input  logic [DATA_W-1:0]     id_busB,
  input  logic [REG_AW-1:0]     id_dst,
  input  logic                  id_regwr,
  input  logic                  id_isload,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  ex_fw_valid,
  input  logic [REG_AW-1:0]     ex_fw_dst,
  input  logic                  ex_fw_regwr,
  input  logic                  ex_fw_isload,
  input  logic [DATA_W-1:0]     ex_fw_result,
  input  logic                  mem_fw_valid,
  input  logic [REG_AW-1:0]     mem_fw_dst,
  input  logic                  mem_fw_regwr,
  input  logic                  mem_fw_data_ok,
  input  logic [DATA_W-1:0]     mem_fw_result,
  input  logic                  wb_rfwr,
  input  logic [REG_AW-1:0]     wb_dst,
  input  logic [DATA_W-1:0]     wb_result,
  input  logic                  ex_allowin,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_opA,
  output logic [DATA_W-1:0]     ex_opB,
  output logic [REG_AW-1:0]     ex_dst,
  output logic                  ex_regwr,
  output logic                  ex_isload,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [PERF_CNT_W-1:0] stall_cnt
);

  logic [DATA_W-1:0] op_a, op_b;
  fwd_sel_e          sel_a, sel_b;
  logic              stall_a, stall_b, hazard, ready_go, take;

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_rs (
    .addr(id_rs), .use_op(id_use_rs), .rf_data(id_busA),
    .ex_fw_valid(ex_fw_valid), .ex_fw_dst(ex_fw_dst), .ex_fw_regwr(ex_fw_regwr),
    .ex_fw_isload(ex_fw_isload), .ex_fw_result(ex_fw_result),
    .mem_fw_valid(mem_fw_valid), .mem_fw_dst(mem_fw_dst), .mem_fw_regwr(mem_fw_regwr),
    .mem_fw_data_ok(mem_fw_data_ok), .mem_fw_result(mem_fw_result),
    .wb_rfwr(wb_rfwr), .wb_dst(wb_dst), .wb_result(wb_result),
    .data(op_a), .sel(sel_a), .stall_req(stall_a)
  );

  operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_rt (
    .addr(id_rt), .use_op(id_use_rt), .rf_data(id_busB),
    .ex_fw_valid(ex_fw_valid), .ex_fw_dst(ex_fw_dst), .ex_fw_regwr(ex_fw_regwr),
    .ex_fw_isload(ex_fw_isload), .ex_fw_result(ex_fw_result),
    .mem_fw_valid(mem_fw_valid), .mem_fw_dst(mem_fw_dst), .mem_fw_regwr(mem_fw_regwr),
    .mem_fw_data_ok(mem_fw_data_ok), .mem_fw_result(mem_fw_result),
    .wb_rfwr(wb_rfwr), .wb_dst(wb_dst), .wb_result(wb_result),
    .data(op_b), .sel(sel_b), .stall_req(stall_b)
  );

  assign hazard     = stall_a | stall_b;
  assign ready_go   = ~hazard;
  assign id_allowin = flush | ~id_valid | (ready_go & ex_allowin);
  assign take       = id_valid & ready_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_opA    <= '0;
      ex_opB    <= '0;
      ex_dst    <= '0;
      ex_regwr  <= 1'b0;
      ex_isload <= 1'b0;
      ex_ctrl   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid <= take;
      // Bubbles leave the payload untouched; only ex_valid drops.
      if (take) begin
        ex_opA    <= op_a;
        ex_opB    <= op_b;
        ex_dst    <= id_dst;
        ex_regwr  <= id_regwr;
        ex_isload <= id_isload;
        ex_ctrl   <= id_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (id_valid && hazard && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with hand-computed expectations.
module tb_id_operand_stage;
  import cpu_pipe_pkg::*;

  logic        clk, rst;
  logic        id_valid, id_allowin;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_use_rs, id_use_rt, id_regwr, id_isload;
  logic [31:0] id_busA, id_busB, id_ctrl;
  logic        ex_fw_valid, ex_fw_regwr, ex_fw_isload;
  logic [4:0]  ex_fw_dst;
  logic [31:0] ex_fw_result;
  logic        mem_fw_valid, mem_fw_regwr, mem_fw_data_ok;
  logic [4:0]  mem_fw_dst;
  logic [31:0] mem_fw_result;
  logic        wb_rfwr;
  logic [4:0]  wb_dst;
  logic [31:0] wb_result;
  logic        ex_allowin, flush;
  logic        ex_valid, ex_regwr, ex_isload;
  logic [31:0] ex_opA, ex_opB, ex_ctrl;
  logic [4:0]  ex_dst;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad = 0;

  id_operand_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(32), .PERF_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_allowin(id_allowin),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_busA(id_busA), .id_busB(id_busB), .id_dst(id_dst), .id_regwr(id_regwr),
    .id_isload(id_isload), .id_ctrl(id_ctrl),
    .ex_fw_valid(ex_fw_valid), .ex_fw_dst(ex_fw_dst), .ex_fw_regwr(ex_fw_regwr),
    .ex_fw_isload(ex_fw_isload), .ex_fw_result(ex_fw_result),
    .mem_fw_valid(mem_fw_valid), .mem_fw_dst(mem_fw_dst), .mem_fw_regwr(mem_fw_regwr),
    .mem_fw_data_ok(mem_fw_data_ok), .mem_fw_result(mem_fw_result),
    .wb_rfwr(wb_rfwr), .wb_dst(wb_dst), .wb_result(wb_result),
    .ex_allowin(ex_allowin), .flush(flush),
    .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_dst(ex_dst),
    .ex_regwr(ex_regwr), .ex_isload(ex_isload), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_busA = 0; id_busB = 0; id_dst = 0; id_regwr = 0; id_isload = 0; id_ctrl = 0;
    ex_fw_valid = 0; ex_fw_dst = 0; ex_fw_regwr = 0; ex_fw_isload = 0; ex_fw_result = 0;
    mem_fw_valid = 0; mem_fw_dst = 0; mem_fw_regwr = 0; mem_fw_data_ok = 0; mem_fw_result = 0;
    wb_rfwr = 0; wb_dst = 0; wb_result = 0;
    ex_allowin = 1; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    rst = 0;
    #12;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_opA", ex_opA, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_allowin", id_allowin, 1);
    @(negedge clk); rst = 1;

    // 1: EX non-load r5 forwarded to rs
    @(negedge clk);
    id_valid = 1; id_rs = 5; id_use_rs = 1; id_busA = 0; id_dst = 7; id_regwr = 1;
    id_ctrl = 32'hA5A5_0001;
    ex_fw_valid = 1; ex_fw_regwr = 1; ex_fw_dst = 5; ex_fw_result = 32'h1234;
    #1 chk("t1_allowin", id_allowin, 1);
    step();
    chk("t1_opA", ex_opA, 32'h1234);
    chk("t1_valid", ex_valid, 1);
    chk("t1_stall_cnt", stall_cnt, 0);
    chk("t1_dst", ex_dst, 7);
    chk("t1_ctrl", ex_ctrl, 32'hA5A5_0001);

    // 2: load-use on rt, then MEM supplies data
    @(negedge clk); quiet();
    id_valid = 1; id_rt = 8; id_use_rt = 1; id_busB = 32'h77;
    ex_fw_valid = 1; ex_fw_regwr = 1; ex_fw_isload = 1; ex_fw_dst = 8;
    #1 chk("t2_allowin_stall", id_allowin, 0);
    step();
    chk("t2_stall_cnt", stall_cnt, 1);
    chk("t2_bubble", ex_valid, 0);
    @(negedge clk);
    ex_fw_valid = 0; ex_fw_isload = 0;
    mem_fw_valid = 1; mem_fw_regwr = 1; mem_fw_dst = 8; mem_fw_data_ok = 1;
    mem_fw_result = 32'hCAFE;
    #1 chk("t2_allowin_go", id_allowin, 1);
    step();
    chk("t2_opB", ex_opB, 32'hCAFE);
    chk("t2_valid", ex_valid, 1);
    chk("t2_stall_cnt_hold", stall_cnt, 1);

    // 3: WB write same cycle as read
    @(negedge clk); quiet();
    id_valid = 1; id_rs = 3; id_use_rs = 1; id_busA = 32'h11;
    wb_rfwr = 1; wb_dst = 3; wb_result = 32'hAA;
    step();
    chk("t3_opA", ex_opA, 32'hAA);

    // 4: EX beats MEM on r9; EX non-load hides a pending MEM load
    @(negedge clk); quiet();
    id_valid = 1; id_rs = 9; id_use_rs = 1;
    ex_fw_valid = 1; ex_fw_regwr = 1; ex_fw_dst = 9; ex_fw_result = 32'h1;
    mem_fw_valid = 1; mem_fw_regwr = 1; mem_fw_dst = 9; mem_fw_data_ok = 0;
    mem_fw_result = 32'h2;
    #1 chk("t4_mask_allowin", id_allowin, 1);
    step();
    chk("t4_opA", ex_opA, 32'h1);
    @(negedge clk);
    mem_fw_data_ok = 1;
    id_rs = 0; id_rt = 0; id_use_rt = 1; id_busA = 32'h55; id_busB = 32'h66; id_dst = 12;
    ex_fw_dst = 0; mem_fw_dst = 0; wb_rfwr = 1; wb_dst = 0; wb_result = 32'h3;
    step();
    chk("t4_r0_opA", ex_opA, 0);
    chk("t4_r0_opB", ex_opB, 0);

    // 5: stall with EX blocked for 3 cycles, then flush
    @(negedge clk); quiet();
    ex_allowin = 0;
    id_valid = 1; id_rs = 4; id_use_rs = 1; id_busA = 32'h99; id_dst = 20;
    ex_fw_valid = 1; ex_fw_regwr = 1; ex_fw_isload = 1; ex_fw_dst = 4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_valid", ex_valid, 1);
      chk("t5_hold_opA", ex_opA, 0);
      chk("t5_hold_dst", ex_dst, 12);
    end
    chk("t5_stall_cnt", stall_cnt, 4);
    @(negedge clk);
    flush = 1;
    #1 chk("t5_flush_allowin", id_allowin, 1);
    step();
    chk("t5_flush_valid", ex_valid, 0);
    chk("t5_flush_nocount", stall_cnt, 4);

    // 6: saturation, then async reset mid-stall
    @(negedge clk);
    flush = 0; ex_allowin = 1;
    for (int i = 0; i < 16; i++) step();
    chk("t6_saturate", stall_cnt, 4'hF);
    chk("t6_bubble", ex_valid, 0);
    #2 rst = 0;
    #1;
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_valid", ex_valid, 0);
    @(negedge clk); rst = 1; quiet();
    step();
    chk("t6_empty_pipe", ex_valid, 0);
    @(negedge clk);
    id_valid = 1; id_rs = 2; id_use_rs = 1; id_busA = 32'hBEEF;
    step();
    chk("t6_restart_valid", ex_valid, 1);
    chk("t6_restart_opA", ex_opA, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
